mem_stage_lsu: RTL

//  Memory-stage load/store unit. Sits between the E/M and M/W pipeline registers; drives read_data_m into the M/W register.

---
 rtl/mem_stage_lsu_pkg.sv | 37 +++
 rtl/mem_stage_lsu_if.sv | 24 ++
 rtl/mem_stage_lsu_load_formatter.sv | 33 +++
 rtl/mem_stage_lsu.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory-stage LSU: funct3 access codes, FSM states and byte-enable patterns.
package mem_stage_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Reserved codes 011/110/111 fall through to a full-word access.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_size = SZ_B;
            F3_H, F3_HU: f3_size = SZ_H;
            F3_W:        f3_size = SZ_W;
            default:     f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory/interconnect (slave): req/gnt request, rvalid response.
interface mem_stage_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_be;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_rvalid;
    logic [DW-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_formatter.sv
// load_formatter: picks the addressed byte/half out of a read word and sign- or zero-extends it (combinational).
module load_formatter
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sext;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        // funct3[2] marks the unsigned (BU/HU) variants
        sext     = ~funct3_i[2];

        case (f3_size(funct3_i))
            SZ_B:    data_o = {{24{byte_sel[7] & sext}}, byte_sel};
            SZ_H:    data_o = {{16{half_sel[15] & sext}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one bus transaction per load/store, stalls the pipeline until it completes.
// Build option MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse misalign_m in DONE.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_read_m,
    input  logic                     mem_write_m,
    input  logic [2:0]               funct3_m,
    input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
    input  logic [DATA_WIDTH-1:0]    write_data_m,
    output logic [DATA_WIDTH-1:0]    read_data_m,
    output logic                     stall_m,
    output logic                     misalign_m,
    mem_stage_lsu_if.master          dmem
);

    lsu_state_e               state_q, state_d;
    logic                     req_q, req_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]               be_q, be_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    load_data_q, load_data_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               off_q, off_d;

    logic                     mem_op;
    logic                     misalign_now;
    lsu_size_e                size_m;
    logic [1:0]               off_m;
    logic [3:0]               lane_be;
    logic [DATA_WIDTH-1:0]    lane_wdata;
    logic [DATA_WIDTH-1:0]    fmt_data;

    assign mem_op = mem_read_m | mem_write_m;
    assign size_m = f3_size(funct3_m);
    assign off_m  = alu_result_m[1:0];

    // Store lane replication lets the memory take data from whichever lane the byte enables select.
    always_comb begin
        case (size_m)
            SZ_B: begin
                lane_be    = BE_BYTE << off_m;
                lane_wdata = {4{write_data_m[7:0]}};
            end
            SZ_H: begin
                lane_be    = BE_HALF << {off_m[1], 1'b0};
                lane_wdata = {2{write_data_m[15:0]}};
            end
            default: begin
                lane_be    = BE_WORD;
                lane_wdata = write_data_m;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign misalign_now = ((size_m == SZ_H) && off_m[0]) ||
                          ((size_m == SZ_W) && (off_m != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end

    always_comb begin
        misalign_d = misalign_q;
        if (state_q == ST_IDLE && mem_op) misalign_d = misalign_now;
    end

    assign misalign_m = misalign_q && (state_q == ST_DONE);
`else
    assign misalign_now = 1'b0;
    assign misalign_m   = 1'b0;
`endif

    load_formatter u_fmt (
        .rdata_i  (dmem.dmem_rdata),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .data_o   (fmt_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op) state_d = misalign_now ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem.dmem_gnt) state_d = we_q ? ST_DONE : ST_RESP;
            ST_RESP: if (dmem.dmem_rvalid) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus registers are loaded once on IDLE->REQ and held until the transaction retires.
    always_comb begin
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        f3_d        = f3_q;
        off_d       = off_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_op && misalign_now) begin
                    load_data_d = '0;
                end else if (mem_op) begin
                    req_d   = 1'b1;
                    we_d    = mem_write_m;
                    addr_d  = {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    f3_d    = funct3_m;
                    off_d   = off_m;
                end
            end
            ST_REQ:  if (dmem.dmem_gnt) req_d = 1'b0;
            ST_RESP: if (dmem.dmem_rvalid) load_data_d = fmt_data;
            default: ;
        endcase

        stall_m     = mem_op && (state_q != ST_DONE);
        read_data_m = load_data_q;
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule
